id1000500a_mem_loader: RTL and testbench
========================================

# id1000500a_mem_loader

Stream-to-memory loader that fills the X and Y operand memories of the ID1000500A convolution core before each run. It accepts a byte stream over a valid/ready handshake and writes the first sizeX beats to memX and the next sizeY beats to memY. It then signals completion and, optionally, starts the core. It sits between the host interface and the memX/memY write ports; the convolution core reads the same memories.

## Interface
- DATA_WIDTH, 8, operand width (memX/memY word and stream beat)
- ADDR_WIDTH, 5, memX/memY address width; max size 2**ADDR_WIDTH-1
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- config_in  in  2*ADDR_WIDTH  sizeX = [ADDR_WIDTH-1:0], sizeY = [2*ADDR_WIDTH-1:ADDR_WIDTH]; same packing as the core
- load_req  in  1  one-cycle request to begin a load; sampled only in IDLE
- s_data  in  DATA_WIDTH  stream beat
- s_valid  in  1  beat valid
- s_ready  out  1  loader can accept a beat
- memX_data  out  DATA_WIDTH  memX write data
- memX_addr  out  ADDR_WIDTH  memX write address
- writeX  out  1  memX write enable
- memY_data  out  DATA_WIDTH  memY write data
- memY_addr  out  ADDR_WIDTH  memY write address
- writeY  out  1  memY write enable
- busy_out  out  1  load in progress
- done_out  out  1  one-cycle completion pulse
- err_out  out  1  sticky: last request had sizeX==0 or sizeY==0
- start_out  out  1  one-cycle core start pulse (see Configuration)

## Operation
- States: IDLE, LOAD_X, LOAD_Y, DONE.
- IDLE, load_req=1:
  - Latch sizeX and sizeY from config_in.
  - Clear the beat counter and err_out.
  - If either size is 0: set err_out and go to DONE without writes.
  - Otherwise go to LOAD_X.
- LOAD_X: s_ready=1. On each accepted beat (s_valid & s_ready):
  - Register writeX=1, memX_addr=counter, memX_data=s_data.
  - Increment the counter.
  - When the accepted beat has counter==sizeX-1: clear the counter and go to LOAD_Y.
- LOAD_Y: same behaviour on the memY port with sizeY. The last beat goes to DONE.
- DONE: lasts one cycle. done_out=1; start_out=1 when enabled and err_out=0. Then go to IDLE.
- Addresses run 0..size-1 and never wrap. Config changes after the request have no effect on the current load.
- load_req outside IDLE is ignored. A beat presented in IDLE or DONE is not accepted (s_ready=0).
- busy_out=1 in LOAD_X, LOAD_Y and DONE.
- Reset, including mid-load: state IDLE and counter 0. Every output is 0: s_ready, writeX, writeY, addresses, data, busy_out, done_out, err_out, start_out. No completion pulse is issued for an aborted load.

## Timing
- Request in cycle t: s_ready=1 from t+1.
- Write latency is 1. A beat accepted in cycle n appears on the write port in cycle n+1, with its enable high for that single cycle.
- Throughput is one beat per cycle. The X-to-Y transition inserts no bubble: the first Y beat may be accepted the cycle after the last X beat.
- Last Y beat accepted in cycle n:
  - n+1: DONE; writeY for that beat; done_out/start_out asserted.
  - n+2: IDLE; busy_out=0.
  - The write commits on the edge ending n+1, before the core can sample memory.
- Zero-size request in cycle t: DONE in t+1 with err_out=1 and done_out=1; IDLE in t+2.
- The handshake is standard valid/ready. s_ready does not depend on s_valid. A stalled s_valid holds the state and the counter.

## Configuration
- ID1000500A_LOADER_AUTOSTART_EN defined: start_out pulses in the DONE cycle of every error-free load. It drives the core's start directly.
- Not defined: start_out is tied to 0, and the core is started by the host after it observes done_out.

## Test plan
- sizeX=3, sizeY=2, beats 0x11,0x22,0x33,0x44,0x55 back-to-back -> memX[0..2]=11,22,33; memY[0..1]=44,55; done_out one cycle after the last writeY beat is accepted, i.e. concurrent with the last writeY.
- Same sizes, s_valid toggled every other cycle -> identical memory contents; counter holds during stalls; no duplicate writes.
- sizeX=0, sizeY=4 -> no writes; err_out=1; done_out 1 cycle after load_req; start_out=0.
- rst asserted after 2 of 5 beats -> all outputs 0 immediately; no done_out; new load_req with sizeX=1, sizeY=1 completes normally with err_out=0.
- load_req pulsed during LOAD_Y, config_in changed mid-load -> ignored; original sizes used.
- sizeX=31, sizeY=31 with AUTOSTART_EN defined -> last addresses 30 on both ports; start_out pulses once, coincident with done_out; without the macro, start_out stays 0.

Source files
------------

// File: rtl/id1000500a_mem_loader_if.sv
// id1000500a_mem_loader_if: stream input and memX/memY write ports of the operand loader
interface id1000500a_mem_loader_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 5
);
   logic [DATA_WIDTH-1:0] s_data;
   logic                  s_valid;
   logic                  s_ready;
   logic [DATA_WIDTH-1:0] memX_data;
   logic [ADDR_WIDTH-1:0] memX_addr;
   logic                  writeX;
   logic [DATA_WIDTH-1:0] memY_data;
   logic [ADDR_WIDTH-1:0] memY_addr;
   logic                  writeY;
   modport master (
      output s_data, s_valid,
      input  s_ready, memX_data, memX_addr, writeX, memY_data, memY_addr, writeY
   );
   modport slave (
      input  s_data, s_valid,
      output s_ready, memX_data, memX_addr, writeX, memY_data, memY_addr, writeY
   );
endinterface

// File: rtl/id1000500a_mem_loader.sv
// id1000500a_mem_loader: fills memX then memY from a byte stream; ID1000500A_LOADER_AUTOSTART_EN enables start_out
module id1000500a_mem_loader #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [2*ADDR_WIDTH-1:0] config_in,
   input  logic                    load_req,
   id1000500a_mem_loader_if.slave  bus,
   output logic                    busy_out,
   output logic                    done_out,
   output logic                    err_out,
   output logic                    start_out
);
`ifdef ID1000500A_LOADER_AUTOSTART_EN
   localparam logic AUTOSTART = 1'b1;
`else
   localparam logic AUTOSTART = 1'b0;
`endif
   typedef enum logic [1:0] {IDLE, LOAD_X, LOAD_Y, DONE} state_t;
   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d, size_x_q, size_x_d, size_y_q, size_y_d;
   logic [ADDR_WIDTH-1:0] x_addr_q, x_addr_d, y_addr_q, y_addr_d, cfg_x, cfg_y;
   logic [DATA_WIDTH-1:0] x_data_q, x_data_d, y_data_q, y_data_d;
   logic                  write_x_q, write_x_d, write_y_q, write_y_d, s_ready_q, s_ready_d;
   logic                  busy_q, busy_d, done_q, done_d, err_q, err_d, start_q, start_d;
   logic                  accept, last;
   assign cfg_x  = config_in[ADDR_WIDTH-1:0];
   assign cfg_y  = config_in[2*ADDR_WIDTH-1:ADDR_WIDTH];
   assign accept = s_ready_q & bus.s_valid;
   assign last   = cnt_q == ((state_q == LOAD_X ? size_x_q : size_y_q) - ADDR_WIDTH'(1));
   // next-state, write port and status decode; outputs are derived from the next state so they are registered
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      size_x_d  = size_x_q;
      size_y_d  = size_y_q;
      err_d     = err_q;
      x_addr_d  = x_addr_q;
      x_data_d  = x_data_q;
      y_addr_d  = y_addr_q;
      y_data_d  = y_data_q;
      write_x_d = 1'b0;
      write_y_d = 1'b0;
      case (state_q)
         IDLE: if (load_req) begin
            size_x_d = cfg_x;
            size_y_d = cfg_y;
            cnt_d    = '0;
            err_d    = (cfg_x == '0) || (cfg_y == '0);
            state_d  = err_d ? DONE : LOAD_X;
         end
         LOAD_X: if (accept) begin
            write_x_d = 1'b1;
            x_addr_d  = cnt_q;
            x_data_d  = bus.s_data;
            cnt_d     = last ? '0 : cnt_q + ADDR_WIDTH'(1);
            state_d   = last ? LOAD_Y : LOAD_X;
         end
         LOAD_Y: if (accept) begin
            write_y_d = 1'b1;
            y_addr_d  = cnt_q;
            y_data_d  = bus.s_data;
            cnt_d     = last ? '0 : cnt_q + ADDR_WIDTH'(1);
            state_d   = last ? DONE : LOAD_Y;
         end
         default: state_d = IDLE;
      endcase
      s_ready_d = (state_d == LOAD_X) || (state_d == LOAD_Y);
      busy_d    = state_d != IDLE;
      done_d    = state_d == DONE;
      start_d   = AUTOSTART && done_d && !err_d;
   end
   // state and output registers; reset aborts any load and silences every output
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         size_x_q  <= '0;
         size_y_q  <= '0;
         err_q     <= 1'b0;
         x_addr_q  <= '0;
         x_data_q  <= '0;
         y_addr_q  <= '0;
         y_data_q  <= '0;
         write_x_q <= 1'b0;
         write_y_q <= 1'b0;
         s_ready_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         start_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         size_x_q  <= size_x_d;
         size_y_q  <= size_y_d;
         err_q     <= err_d;
         x_addr_q  <= x_addr_d;
         x_data_q  <= x_data_d;
         y_addr_q  <= y_addr_d;
         y_data_q  <= y_data_d;
         write_x_q <= write_x_d;
         write_y_q <= write_y_d;
         s_ready_q <= s_ready_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         start_q   <= start_d;
      end
   end
   assign bus.s_ready   = s_ready_q;
   assign bus.memX_data = x_data_q;
   assign bus.memX_addr = x_addr_q;
   assign bus.writeX    = write_x_q;
   assign bus.memY_data = y_data_q;
   assign bus.memY_addr = y_addr_q;
   assign bus.writeY    = write_y_q;
   assign busy_out      = busy_q;
   assign done_out      = done_q;
   assign err_out       = err_q;
   assign start_out     = start_q;
endmodule

// File: tb/tb_id1000500a_mem_loader.sv
// tb_id1000500a_mem_loader: scoreboard bench for the memX/memY stream loader
module tb_id1000500a_mem_loader;
   localparam int DW = 8;
   localparam int AW = 5;
`ifdef ID1000500A_LOADER_AUTOSTART_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif
   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            load_req = 1'b0;
   logic [2*AW-1:0] config_in = '0;
   logic            busy_out, done_out, err_out, start_out;
   int n_tests = 0, n_fail = 0, cyc = 0, t_req = 0;
   int done_cnt = 0, start_cnt = 0, wx_cnt = 0, wy_cnt = 0;
   int done_cyc = 0, last_wy_cyc = 0, last_xa = 0, last_ya = 0;
   logic [AW+DW-1:0] qx[$], qy[$], e;
   id1000500a_mem_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
   id1000500a_mem_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst), .config_in(config_in), .load_req(load_req), .bus(bus.slave),
      .busy_out(busy_out), .done_out(done_out), .err_out(err_out), .start_out(start_out)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   function automatic logic [63:0] all_outs();
      return {bus.s_ready, bus.writeX, bus.writeY, bus.memX_addr, bus.memX_data,
              bus.memY_addr, bus.memY_data, busy_out, done_out, err_out, start_out};
   endfunction
   // monitor: pop the expected write for every enabled write port, track completion pulses
   always @(negedge clk) begin
      if (bus.writeX) begin
         wx_cnt++;
         last_xa = int'(bus.memX_addr);
         if (qx.size() == 0) check("x_unexpected", 1, 0);
         else begin
            e = qx.pop_front();
            check("x_write", {bus.memX_addr, bus.memX_data}, e);
         end
      end
      if (bus.writeY) begin
         wy_cnt++;
         last_ya = int'(bus.memY_addr);
         last_wy_cyc = cyc;
         if (qy.size() == 0) check("y_unexpected", 1, 0);
         else begin
            e = qy.pop_front();
            check("y_write", {bus.memY_addr, bus.memY_data}, e);
         end
      end
      if (done_out) begin
         done_cnt++;
         done_cyc = cyc;
         check("ready_in_done", bus.s_ready, 0);
      end
      if (start_out) begin
         start_cnt++;
         check("start_with_done", done_out, 1);
      end
   end
   // all tasks start and end 1 time unit after a rising edge
   task automatic req(input int sx, input int sy);
      config_in = {sy[AW-1:0], sx[AW-1:0]};
      load_req  = 1'b1;
      t_req     = cyc;
      @(posedge clk); #1;
      load_req  = 1'b0;
      config_in = (2*AW)'($urandom);
   endtask
   task automatic send_beat(input bit is_y, input int addr, input bit poke, input logic [DW-1:0] d);
      int w = 0;
      bus.s_valid = 1'b1;
      bus.s_data  = d;
      if (poke) begin
         load_req  = 1'b1;
         config_in = (2*AW)'($urandom);
      end
      forever begin
         @(negedge clk);
         if (bus.s_ready) break;
         w++;
         if (w > 20) begin
            check("ready_timeout", 0, 1);
            bus.s_valid = 1'b0;
            load_req = 1'b0;
            return;
         end
         @(posedge clk); #1;
      end
      @(posedge clk);
      if (is_y) qy.push_back({addr[AW-1:0], d});
      else qx.push_back({addr[AW-1:0], d});
      #1;
      bus.s_valid = 1'b0;
      load_req = 1'b0;
   endtask
   task automatic do_load(input int sx, input int sy, input bit gap, input bit poke, input int salt);
      int d0 = done_cnt, s0 = start_cnt, x0 = wx_cnt, y0 = wy_cnt, w = 0;
      bit zero = (sx == 0) || (sy == 0);
      req(sx, sy);
      check("ready_after_req", bus.s_ready, !zero);
      if (zero) check("zero_done_now", {done_out, err_out, busy_out}, 3'b111);
      else for (int b = 0; b < sx + sy; b++) begin
         send_beat(b >= sx, b < sx ? b : b - sx, poke && b == sx, DW'((b + 1) * 17 + salt));
         if (gap) begin
            @(posedge clk); #1;
         end
      end
      while (done_cnt == d0 && w < 10) begin
         @(posedge clk); #1;
         w++;
      end
      check("done_count", done_cnt - d0, 1);
      check("done_time", done_cyc, zero ? t_req + 1 : last_wy_cyc);
      check("err", err_out, zero);
      check("start_count", start_cnt - s0, AUTO && !zero);
      check("x_writes", wx_cnt - x0, zero ? 0 : sx);
      check("y_writes", wy_cnt - y0, zero ? 0 : sy);
      check("queues_empty", qx.size() + qy.size(), 0);
      @(negedge clk);
      check("idle_after", {busy_out, bus.s_ready, done_out, start_out}, 0);
      @(posedge clk); #1;
   endtask
   initial begin
      int d0;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_outputs", all_outs(), 0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("idle_outputs", all_outs(), 0);
      do_load(3, 2, 1'b0, 1'b0, 0);
      do_load(3, 2, 1'b1, 1'b0, 5);
      do_load(0, 4, 1'b0, 1'b0, 0);
      d0 = done_cnt;
      req(3, 2);
      send_beat(1'b0, 0, 1'b0, 8'hA1);
      send_beat(1'b0, 1, 1'b0, 8'hA2);
      @(negedge clk); #1;
      rst = 1'b1;
      #1;
      check("rst_async_outputs", all_outs(), 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("no_done_on_abort", done_cnt - d0, 0);
      check("abort_queue", qx.size() + qy.size(), 0);
      do_load(1, 1, 1'b0, 1'b0, 9);
      do_load(4, 0, 1'b0, 1'b0, 0);
      do_load(3, 2, 1'b0, 1'b1, 33);
      do_load(31, 31, 1'b0, 1'b0, 77);
      check("last_x_addr", last_xa, 30);
      check("last_y_addr", last_ya, 30);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
